filter_p_m_ctrl: RTL and testbench

- Digital-core counterpart of the analog filter_p_m macro.
- Generates the filter's digital drive signals: cclk, div2, the LO and fb1 feedback.
- Samples the comparator output high_buf on each phi1b_dig rising edge and closes the 1-bit feedback loop.
- Emits polarity-change events over a valid/ready handshake, plus windowed ones-count (density) results.

---
 rtl/filter_ctrl_pkg.sv | 13 +
 rtl/filter_clkgen.sv | 66 ++++++
 rtl/filter_p_m_ctrl.sv | 139 +++++++++++++
 tb/tb_filter_p_m_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// filter_ctrl_pkg : shared widths and sampling-latency constants
// Rev 1.0
// ============================================================================
package filter_ctrl_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int WIN_W_DEF   = 10;
    localparam int TS_W_DEF    = 16;
    localparam int SYNC_STAGES = 2;
    localparam int EDGE_LAT    = 3;
endpackage
`default_nettype wire

// File: rtl/filter_clkgen.sv
`default_nettype none
// ============================================================================
// filter_clkgen : cclk divider, div2 and LO generation with enable gating
// Rev 1.0
// ============================================================================
module filter_clkgen
    import filter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic [7:0]       lo_ratio,
    output logic             cclk,
    output logic             div2,
    output logic             lo
);
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_last;
    logic [7:0]       lo_cnt;
    logic [8:0]       lo_cnt_nx;
    logic             div_tc;
    logic             cclk_rise;

    // >= keeps a shrinking ratio from running the counters past terminal
    assign div_last  = (div_ratio == '0) ? '0 : div_ratio - CNT_W'(1);
    assign div_tc    = (div_cnt >= div_last);
    assign cclk_rise = div_tc & ~cclk;
    assign lo_cnt_nx = {1'b0, lo_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (!rstb || !en) begin
            div_cnt <= '0;
            cclk    <= 1'b0;
            div2    <= 1'b0;
            lo_cnt  <= '0;
            lo      <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                cclk    <= ~cclk;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end

            if (cclk_rise) begin
                div2 <= ~div2;
            end

            if (lo_ratio == 8'd0) begin
                lo_cnt <= '0;
                lo     <= 1'b0;
            end else if (cclk_rise) begin
                if (lo_cnt_nx >= {1'b0, lo_ratio}) begin
                    lo_cnt <= '0;
                    lo     <= ~lo;
                end else begin
                    lo_cnt <= lo_cnt_nx[7:0];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/filter_p_m_ctrl.sv
`default_nettype none
// ============================================================================
// filter_p_m_ctrl : digital control for filter_p_m (drive clocks, feedback,
// polarity-change events and windowed ones-density)
// Rev 1.0
// ============================================================================
module filter_p_m_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic [7:0]       lo_ratio,
    input  logic [WIN_W-1:0] win_len,
    input  logic             high_buf,
    input  logic             phi1b_dig,
    output logic             cclk,
    output logic             div2,
    output logic             lo,
    output logic             fb1,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_pol,
    output logic [TS_W-1:0]  evt_ts,
    output logic             win_valid,
    output logic [WIN_W-1:0] win_count,
    output logic             dropped,
    input  logic             clr_drop
);
    // Edge is visible SYNC_STAGES-1 cycles after capture; retime it to EDGE_LAT
    localparam int DET_DLY = EDGE_LAT - SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] hb_sync;
    logic [SYNC_STAGES-1:0] phi_sync;
    logic                   phi_d;
    logic [DET_DLY-1:0]     det_pipe;
    logic                   rise;
    logic                   bit_now;
    logic                   samp_en;
    logic                   prev_bit;
    logic [TS_W-1:0]        ts;
    logic [WIN_W-1:0]       samp_cnt;
    logic [WIN_W-1:0]       ones_cnt;
    logic [WIN_W-1:0]       ones_nx;
    logic [WIN_W-1:0]       win_eff;
    logic [WIN_W:0]         samp_nx;
    logic                   win_done;

    filter_clkgen #(.CNT_W(CNT_W)) u_clkgen (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .div_ratio (div_ratio),
        .lo_ratio  (lo_ratio),
        .cclk      (cclk),
        .div2      (div2),
        .lo        (lo)
    );

    assign rise     = phi_sync[SYNC_STAGES-1] & ~phi_d;
    assign bit_now  = hb_sync[SYNC_STAGES-1];
    assign samp_en  = en & det_pipe[DET_DLY-1];
    assign win_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
    assign samp_nx  = {1'b0, samp_cnt} + (WIN_W+1)'(1);
    assign ones_nx  = (bit_now && (ones_cnt != '1)) ? ones_cnt + WIN_W'(1) : ones_cnt;
    assign win_done = (samp_nx >= {1'b0, win_eff});

    always_ff @(posedge clk) begin
        if (!rstb) begin
            hb_sync  <= '0;
            phi_sync <= '0;
            phi_d    <= 1'b0;
            det_pipe <= '0;
        end else begin
            hb_sync  <= {hb_sync[SYNC_STAGES-2:0], high_buf};
            phi_sync <= {phi_sync[SYNC_STAGES-2:0], phi1b_dig};
            phi_d    <= phi_sync[SYNC_STAGES-1];
            det_pipe <= {det_pipe[DET_DLY-2:0], rise};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            fb1       <= 1'b0;
            prev_bit  <= 1'b0;
            ts        <= '0;
            evt_valid <= 1'b0;
            evt_pol   <= 1'b0;
            evt_ts    <= '0;
            dropped   <= 1'b0;
            win_valid <= 1'b0;
            win_count <= '0;
            samp_cnt  <= '0;
            ones_cnt  <= '0;
        end else begin
            win_valid <= 1'b0;
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (clr_drop) begin
                dropped <= 1'b0;
            end

            if (!en) begin
                samp_cnt <= '0;
                ones_cnt <= '0;
            end else if (samp_en) begin
                fb1 <= bit_now;
                ts  <= ts + TS_W'(1);
                // A drop assigned after the clr_drop clear wins on a tie
                if (bit_now != prev_bit) begin
                    prev_bit <= bit_now;
                    if (!evt_valid || evt_ready) begin
                        evt_valid <= 1'b1;
                        evt_pol   <= bit_now;
                        evt_ts    <= ts;
                    end else begin
                        dropped <= 1'b1;
                    end
                end
                if (win_done) begin
                    win_valid <= 1'b1;
                    win_count <= ones_nx;
                    samp_cnt  <= '0;
                    ones_cnt  <= '0;
                end else begin
                    samp_cnt <= samp_nx[WIN_W-1:0];
                    ones_cnt <= ones_nx;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_filter_p_m_ctrl.sv
`default_nettype none
// ============================================================================
// tb_filter_p_m_ctrl : self-checking bench for filter_p_m_ctrl
// Rev 1.0
// ============================================================================
module tb_filter_p_m_ctrl;
    logic       clk = 1'b0;
    logic       rstb, en, high_buf, phi1b_dig, evt_ready, clr_drop;
    logic [7:0] div_ratio, lo_ratio;
    logic [9:0] win_len;
    logic       cclk, div2, lo, fb1, evt_valid, evt_pol, win_valid, dropped;
    logic [3:0] evt_ts;
    logic [9:0] win_count;

    int checks = 0;
    int failures = 0;

    filter_p_m_ctrl #(.CNT_W(8), .WIN_W(10), .TS_W(4)) dut (
        .clk(clk), .rstb(rstb), .en(en), .div_ratio(div_ratio), .lo_ratio(lo_ratio),
        .win_len(win_len), .high_buf(high_buf), .phi1b_dig(phi1b_dig),
        .cclk(cclk), .div2(div2), .lo(lo), .fb1(fb1), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_pol(evt_pol), .evt_ts(evt_ts),
        .win_valid(win_valid), .win_count(win_count), .dropped(dropped),
        .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] div_r;
        logic [7:0] lo_r;
        int         cclk_p;
        int         div2_p;
        int         lo_p;
    } div_vec_t;
    div_vec_t dv[4];

    // Reference model state: pending event, drop flag, sample history
    logic m_valid, m_pol, m_drop, m_prev, m_fb, m_prev_r;
    int   m_evts, m_ts, m_samp, m_ones;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pol = 0; m_drop = 0; m_prev = 0; m_fb = 0; m_prev_r = 0;
        m_evts = 0; m_ts = 0; m_samp = 0; m_ones = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rstb = 1'b0; evt_ready = 1'b0; clr_drop = 1'b0;
        @(negedge clk); rstb = 1'b1;
        model_reset();
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       pick = cclk;
            1:       pick = div2;
            default: pick = lo;
        endcase
    endfunction

    // Period between the first two rising edges; 0 when fewer than two occur in 200 cycles
    task automatic measure(input int which, output int per);
        int   t1;
        logic pv, v;
        bit   done;
        t1 = -1; per = 0; done = 0;
        pv = pick(which);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            v = pick(which);
            if (v && !pv) begin
                if (t1 < 0) t1 = c;
                else begin per = c - t1; done = 1; end
            end
            pv = v;
        end
    endtask

    // One phi1b_dig pulse carrying comparator bit hb. Called on a negedge,
    // returns on a negedge. clr: 0 none, 1 early pulse, 2 pulse on the sample cycle.
    task automatic sample(input logic hb, input logic rdy, input logic late, input int clr);
        logic dropped_now, exp_wv;
        int   eff, exp_wc;
        high_buf = hb; phi1b_dig = 1'b1;
        evt_ready = late ? 1'b0 : rdy;
        clr_drop = (clr == 1);

        if (m_prev_r || (rdy && !late)) m_valid = 0;
        if (clr == 1) m_drop = 0;
        dropped_now = 0;
        if (hb != m_prev) begin
            m_prev = hb;
            if (!m_valid || rdy || late) begin
                m_valid = 1; m_pol = hb; m_evts = m_ts;
            end else begin
                m_drop = 1; dropped_now = 1;
            end
        end else if (m_valid && (rdy || late)) begin
            m_valid = 0;
        end
        if (clr == 2 && !dropped_now) m_drop = 0;
        m_ts = (m_ts + 1) % 16;
        eff = (win_len == 0) ? 1 : int'(win_len);
        m_samp++;
        if (hb && m_ones < 1023) m_ones++;
        exp_wv = (m_samp >= eff);
        exp_wc = m_ones;
        if (exp_wv) begin m_samp = 0; m_ones = 0; end

        @(negedge clk); clr_drop = 1'b0;
        @(negedge clk); phi1b_dig = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fb1_before_D", fb1, m_fb);
        check("win_valid_early", win_valid, 0);
        if (late) evt_ready = 1'b1;
        if (clr == 2) clr_drop = 1'b1;
        @(negedge clk);
        clr_drop = 1'b0;
        m_fb = hb;
        check("fb1", fb1, m_fb);
        check("evt_valid", evt_valid, m_valid);
        if (m_valid) begin
            check("evt_pol", evt_pol, m_pol);
            check("evt_ts", evt_ts, m_evts);
        end
        check("dropped", dropped, m_drop);
        check("win_valid", win_valid, exp_wv);
        if (exp_wv) check("win_count", win_count, exp_wc);
        m_prev_r = rdy || late;
        @(negedge clk);
        check("win_valid_pulse", win_valid, 0);
    endtask

    initial begin
        int   p;
        logic hb, rdy, late;
        int   clr;

        dv[0] = '{div_r: 8'd3, lo_r: 8'd2, cclk_p: 6,  div2_p: 12, lo_p: 24};
        dv[1] = '{div_r: 8'd0, lo_r: 8'd1, cclk_p: 2,  div2_p: 4,  lo_p: 4};
        dv[2] = '{div_r: 8'd1, lo_r: 8'd3, cclk_p: 2,  div2_p: 4,  lo_p: 12};
        dv[3] = '{div_r: 8'd5, lo_r: 8'd0, cclk_p: 10, div2_p: 20, lo_p: 0};

        rstb = 1'b0; en = 1'b1; div_ratio = 8'd3; lo_ratio = 8'd2; win_len = 10'd4;
        high_buf = 1'b1; phi1b_dig = 1'b0; evt_ready = 1'b1; clr_drop = 1'b0;
        model_reset();

        // Reset holds every output low even with en asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  {cclk, div2, lo, fb1, evt_valid, evt_pol, evt_ts, win_valid, win_count, dropped}, 0);
        end
        rstb = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            div_ratio = dv[i].div_r; lo_ratio = dv[i].lo_r; en = 1'b0;
            @(negedge clk); en = 1'b1;
            measure(0, p); check("cclk_period", p, dv[i].cclk_p);
            measure(1, p); check("div2_period", p, dv[i].div2_p);
            measure(2, p); check("lo_period", p, dv[i].lo_p);
        end

        // Feedback latency and first event
        do_reset();
        win_len = 10'd4;
        sample(1'b1, 1'b0, 1'b0, 0);
        check("lat_evt_valid", evt_valid, 1);
        check("lat_evt_pol", evt_pol, 1);
        check("lat_evt_ts", evt_ts, 0);

        // Handshake: stalled consumer drops, pending event survives
        sample(1'b0, 1'b0, 1'b0, 0);
        sample(1'b1, 1'b0, 1'b0, 0);
        check("hold_pol", evt_pol, 1);
        check("hold_ts", evt_ts, 0);
        check("drop_set", dropped, 1);
        sample(1'b0, 1'b0, 1'b1, 0);
        check("same_cycle_pol", evt_pol, 0);
        check("same_cycle_ts", evt_ts, 3);
        check("same_cycle_drop", dropped, 1);
        sample(1'b0, 1'b1, 1'b0, 1);
        check("clr_drop", dropped, 0);
        sample(1'b1, 1'b0, 1'b0, 0);
        sample(1'b0, 1'b0, 1'b0, 2);
        check("drop_beats_clr", dropped, 1);

        // Window density
        do_reset();
        win_len = 10'd4;
        sample(1'b1, 1'b1, 1'b0, 0);
        sample(1'b0, 1'b1, 1'b0, 0);
        sample(1'b1, 1'b1, 1'b0, 0);
        sample(1'b1, 1'b1, 1'b0, 0);
        check("win4_count", win_count, 3);
        win_len = 10'd0;
        sample(1'b0, 1'b1, 1'b0, 0);
        check("win0_count0", win_count, 0);
        sample(1'b1, 1'b1, 1'b0, 0);
        check("win0_count1", win_count, 1);

        // Timestamp wrap with 4-bit timestamp
        do_reset();
        for (int i = 0; i < 17; i++) sample(((i % 2) == 0), 1'b1, 1'b0, 0);
        check("ts_wrap", evt_ts, 0);

        // en low mid-window restarts the window
        do_reset();
        win_len = 10'd4;
        sample(1'b1, 1'b1, 1'b0, 0);
        sample(1'b1, 1'b1, 1'b0, 0);
        en = 1'b0;
        m_samp = 0; m_ones = 0;
        repeat (4) @(negedge clk);
        check("en0_clocks", {cclk, div2, lo}, 0);
        en = 1'b1;
        sample(1'b1, 1'b1, 1'b0, 0);
        sample(1'b0, 1'b1, 1'b0, 0);
        sample(1'b0, 1'b1, 1'b0, 0);
        sample(1'b0, 1'b1, 1'b0, 0);
        check("en_restart_count", win_count, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) win_len = 10'($urandom_range(0, 5));
            hb   = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            late = !rdy && ($urandom_range(0, 3) == 0);
            clr  = $urandom_range(0, 5);
            if (clr > 2) clr = 0;
            sample(hb, rdy, late, clr);
        end

        // Reset while an event is pending
        sample(~m_prev, 1'b0, 1'b0, 0);
        sample(~m_prev, 1'b0, 1'b0, 0);
        check("pre_reset_valid", evt_valid, 1);
        rstb = 1'b0;
        @(negedge clk);
        check("reset_evt_valid", evt_valid, 0);
        check("reset_dropped", dropped, 0);
        rstb = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
